// File: rtl/memio_arbiter.sv
// Purpose : two-master (CPU, DMA) arbiter in front of a single-port memio block.
// Latency : grant is combinational in the request cycle; read data returns exactly one cycle after grant.
// Backpressure : CPU wins by default. A waiting DMA is forced through after STARVE_LIMIT cycles. Losers see no gnt and hold their request.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   c_* / d_*         - CPU / DMA request (req, we, addr, wdata), grant, read return (rvalid, rdata)
//   c_stall           - CPU request not accepted this cycle (freezes EX/MEM)
//   m_*               - memio side: enable, write strobe, address, write data, read data
module memio_arbiter #(
   parameter int AW           = 23,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_stall,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   // Lowest address of the I/O status window (dipswitch, timer command, ...).
   localparam logic [AW-1:0] STATUS_LO = AW'(23'h7FFFBC);

   logic [7:0]    starve_cnt;
   logic          rd_pend;
   logic          rd_owner_dma;
   logic [AW-1:0] rd_addr;

   logic          force_dma;
   logic          c_blk;
   logic          d_blk;

   always_comb begin
      force_dma = (starve_cnt >= 8'(STARVE_LIMIT));
      // A status read must not be re-issued while the identical read is still
      // returning; status reads can have side effects, so the requester waits a cycle.
      c_blk = rd_pend & ~c_we & (c_addr >= STATUS_LO) & (c_addr == rd_addr);
      d_blk = rd_pend & ~d_we & (d_addr >= STATUS_LO) & (d_addr == rd_addr);

      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!rst) begin
         if (d_req && !d_blk && force_dma) begin
            d_gnt = 1'b1;
         end else if (c_req && !c_blk) begin
            c_gnt = 1'b1;
         end else if (d_req && !d_blk) begin
            d_gnt = 1'b1;
         end
      end

      c_stall = c_req & ~c_gnt;
      m_en    = c_gnt | d_gnt;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (c_gnt) begin
         m_we    = c_we;
         m_addr  = c_addr;
         m_wdata = c_wdata;
      end else if (d_gnt) begin
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end

      // rst gating discards a read that was pending when reset arrived.
      c_rvalid = ~rst & rd_pend & ~rd_owner_dma;
      d_rvalid = ~rst & rd_pend &  rd_owner_dma;
      c_rdata  = c_rvalid ? m_rdata : '0;
      d_rdata  = d_rvalid ? m_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt   <= '0;
         rd_pend      <= 1'b0;
         rd_owner_dma <= 1'b0;
         rd_addr      <= '0;
      end else begin
         if (d_gnt || !d_req) begin
            starve_cnt <= '0;
         end else if (starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
         end
         rd_pend      <= m_en & ~m_we;
         rd_owner_dma <= d_gnt;
         rd_addr      <= m_addr;
      end
   end

endmodule

// File: doc/memio_arbiter.md
MEMIO_ARBITER -- requirements
Module: memio_arbiter

Interface
REQ-001 Parameter: AW, 23, word-address width.
REQ-002 Parameter: DW, 32, data width.
REQ-003 Parameter: STARVE_LIMIT, 8, consecutive cycles DMA may wait before forced grant (range 1..255).
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 c_req  in  1  CPU MEM-stage access request.
REQ-007 c_we  in  1  CPU write (1) / read (0).
REQ-008 c_addr  in  AW  CPU word address.
REQ-009 c_wdata  in  DW  CPU write data.
REQ-010 c_gnt  out  1  CPU access accepted this cycle.
REQ-011 c_stall  out  1  c_req & ~c_gnt; freezes the EX/MEM register.
REQ-012 c_rvalid  out  1  CPU read data valid.
REQ-013 c_rdata  out  DW  CPU read data.
REQ-014 d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  DMA requester, same meaning as the CPU port.
REQ-015 d_gnt, d_rvalid  out  1  DMA grant / read valid; d_rdata  out  DW  DMA read data.
REQ-016 m_en, m_we  out  1  memio enable / write strobe.
REQ-017 m_addr  out  AW  drives memio writeAddr and readAddr; m_wdata  out  DW  memio din.
REQ-018 m_rdata  in  DW  memio dout.

Function
REQ-019 Grant is combinational from the current requests and registered state; at most one of c_gnt/d_gnt is high in any cycle.
REQ-020 Default priority is CPU: c_req=1 -> c_gnt=1, unless the force flag is set.
REQ-021 starve_cnt (8-bit) increments each cycle with d_req=1 and d_gnt=0; it clears on d_gnt or when d_req=0.
REQ-022 force flag = (starve_cnt >= STARVE_LIMIT); when set and d_req=1, d_gnt=1 and c_gnt=0 for exactly that cycle.
REQ-023 Outputs when a requester is granted:
- m_en=1.
- m_we = granted requester's we.
- m_addr and m_wdata = granted requester's signals.
REQ-024 No grant: m_en=0, m_we=0, m_addr=0, m_wdata=0.
REQ-025 Read return tag (registered):
- On a granted read, rd_owner latches CPU/DMA and rd_pend is set to 1; otherwise rd_pend is cleared to 0.
- Read latency is exactly 1 cycle after grant.
REQ-026 c_rvalid = rd_pend & owner==CPU; d_rvalid = rd_pend & owner==DMA.
REQ-027 m_rdata is routed to the owner's rdata; the non-owner's rdata is 0.
REQ-028 Writes produce no rvalid.
REQ-029 Back-to-back grants are allowed every cycle, including read followed by write, with no bubble.
REQ-030 A requester holds req/we/addr/wdata stable until it sees gnt=1; the arbiter does not buffer requests.
REQ-031 Simultaneous c_req and d_req with the force flag clear: CPU is granted and starve_cnt increments.
REQ-032 starve_cnt saturates at 255.
REQ-033 Status-address rule (protects I/O side effects such as the dipswitch read and the timer command):
- Reads of addresses 0x7FFFBC..0x7FFFFF are never granted in a cycle where rd_pend=1 and that pending read targets the same address.
- The requester stalls one cycle instead.

Reset
REQ-034 While rst=1 the following are 0: c_gnt, d_gnt, m_en, m_we, m_addr, m_wdata, c_rvalid, d_rvalid, c_rdata, d_rdata, starve_cnt, rd_pend.
REQ-035 rst=1 during a pending read discards the read: no rvalid is issued in the following cycle.
REQ-036 The first grant may occur in the first cycle with rst=0.

Verification
REQ-037 CPU read alone:
- Stimulus: c_req=1, c_we=0, c_addr=0x7FFFFF.
- Response: c_gnt=1, m_en=1, m_addr=0x7FFFFF; next cycle c_rvalid=1, c_rdata=m_rdata, d_rvalid=0.
REQ-038 Starvation, STARVE_LIMIT=8:
- Stimulus: c_req and d_req held high continuously.
- Response: c_gnt on cycles 0-7; d_gnt on cycle 8 with c_stall=1; CPU regains grant on cycle 9.
REQ-039 Interleave:
- Stimulus: DMA write 0x7FFFFC data 0x12345678, then CPU read 0x7FFFFC on the next cycle.
- Response: m_we=1, m_wdata=0x12345678 in cycle 0; cycle 1 m_en=1, m_we=0; c_rvalid=1 in cycle 2.
REQ-040 Repeated status read:
- Stimulus: CPU reads 0x7FFFFE on two consecutive cycles.
- Response: second access stalled one cycle (c_stall=1), then granted.
REQ-041 Reset mid-read:
- Stimulus: DMA read granted in cycle N, rst=1 in cycle N+1.
- Response: d_rvalid=0 in cycles N+1 and N+2; starve_cnt=0.
REQ-042 Idle:
- Stimulus: no requests for 20 cycles.
- Response: m_en=0, all rvalid=0, starve_cnt stays 0.
